// File: rtl/serial_mag_comp_ctrl.sv
// -----------------------------------------------------------------------------
// serial_mag_comp_ctrl
//
// Sequential unsigned magnitude comparator. Two WIDTH-bit operands are latched
// on an accepted start, then examined one 2-bit pair per clock, MSB pair
// first, through a single 2-bit compare slice. The first unequal pair decides
// the verdict and ends the compare early. Equal operands walk all pairs.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   compare request, sampled only while idle
//   A, B   in   WIDTH-bit operands, captured when start is accepted
//   busy   out  high while a compare is running or reporting (RUN, DONE)
//   done   out  one-cycle pulse; E/G/L/steps are valid from this cycle
//   E/G/L  out  registered verdict: A==B, A>B, A<B (unsigned)
//   steps  out  number of bit-pairs examined by the last compare
// -----------------------------------------------------------------------------
module serial_mag_comp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WIDTH-1:0]            A,
    input  logic [WIDTH-1:0]            B,
    output logic                        busy,
    output logic                        done,
    output logic                        E,
    output logic                        G,
    output logic                        L,
    output logic [$clog2(WIDTH/2):0]    steps
);

    localparam int NPAIRS = WIDTH / 2;
    localparam int IDXW   = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam int STEPW  = $clog2(NPAIRS) + 1;

    // Odd or too-small widths cannot be split into 2-bit pairs.
    if ((WIDTH % 2 != 0) || (WIDTH < 2)) begin : g_bad_width
        $error("serial_mag_comp_ctrl: WIDTH must be even and >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state,  w_state_next;
    logic [WIDTH-1:0]       r_a,      w_a_next;
    logic [WIDTH-1:0]       r_b,      w_b_next;
    logic [IDXW-1:0]        r_idx,    w_idx_next;
    logic [STEPW-1:0]       r_cnt,    w_cnt_next;
    logic                   r_e,      w_e_next;
    logic                   r_g,      w_g_next;
    logic                   r_l,      w_l_next;
    logic [STEPW-1:0]       r_steps,  w_steps_next;

    // Split the latched operands into 2-bit pairs; pair gi covers bits
    // [2*gi+1 : 2*gi].
    logic [1:0] w_pair_a [NPAIRS];
    logic [1:0] w_pair_b [NPAIRS];

    for (genvar gi = 0; gi < NPAIRS; gi++) begin : g_pairs
        assign w_pair_a[gi] = r_a[2*gi +: 2];
        assign w_pair_b[gi] = r_b[2*gi +: 2];
    end

    // The shared 2-bit compare slice, fed by the pair under the index.
    logic [1:0] w_cur_a;
    logic [1:0] w_cur_b;
    logic       w_slice_g;
    logic       w_slice_l;

    assign w_cur_a   = w_pair_a[r_idx];
    assign w_cur_b   = w_pair_b[r_idx];
    assign w_slice_g = (w_cur_a > w_cur_b);
    assign w_slice_l = (w_cur_a < w_cur_b);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_e     <= 1'b0;
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_steps <= '0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_e     <= w_e_next;
            r_g     <= w_g_next;
            r_l     <= w_l_next;
            r_steps <= w_steps_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_e_next     = r_e;
        w_g_next     = r_g;
        w_l_next     = r_l;
        w_steps_next = r_steps;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_a_next     = A;
                    w_b_next     = B;
                    w_idx_next   = IDXW'(NPAIRS - 1);
                    w_cnt_next   = '0;
                    w_state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                w_cnt_next = r_cnt + STEPW'(1);
                if (w_cur_a != w_cur_b) begin
                    // First unequal pair from the top settles the verdict.
                    w_e_next     = 1'b0;
                    w_g_next     = w_slice_g;
                    w_l_next     = w_slice_l;
                    w_steps_next = r_cnt + STEPW'(1);
                    w_state_next = ST_DONE;
                end else if (r_idx == '0) begin
                    // All pairs matched.
                    w_e_next     = 1'b1;
                    w_g_next     = 1'b0;
                    w_l_next     = 1'b0;
                    w_steps_next = STEPW'(NPAIRS);
                    w_state_next = ST_DONE;
                end else begin
                    w_idx_next = r_idx - IDXW'(1);
                end
            end

            ST_DONE: begin
                // Requests seen here are dropped, not queued.
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy  = (r_state != ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign E     = r_e;
    assign G     = r_g;
    assign L     = r_l;
    assign steps = r_steps;

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_mag_comp_ctrl
//
// Scoreboard bench: the stimulus process decides from a timing model when a
// request is accepted and pushes the expected verdict; an independent monitor
// pops and compares on every done pulse and checks the held result between
// pulses.
// -----------------------------------------------------------------------------
module tb_serial_mag_comp_ctrl;

    localparam int W  = 8;
    localparam int NP = W / 2;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic           E;
    logic           G;
    logic           L;
    logic [$clog2(NP):0] steps;

    serial_mag_comp_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .E     (E),
        .G     (G),
        .L     (L),
        .steps (steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           e;
        int           g;
        int           l;
        int           k;
        int           done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   model_free = 0;   // earliest posedge count at which a start is taken

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain unsigned compare; pairs examined follow from the
    // position of the highest differing bit.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        logic [W-1:0] x;
        int msb;
        r.a = a;
        r.b = b;
        r.e = (a == b) ? 1 : 0;
        r.g = (a > b)  ? 1 : 0;
        r.l = (a < b)  ? 1 : 0;
        r.done_cyc = 0;
        if (a == b) begin
            r.k = NP;
        end else begin
            x = a ^ b;
            msb = 0;
            for (int i = 0; i < W; i++) if (x[i]) msb = i;
            r.k = NP - (msb / 2);
        end
        return r;
    endfunction

    // Drive one cycle of inputs; if the model says the controller is idle at
    // the coming edge, the request is accepted and its result is expected.
    task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        @(negedge clk);
        start = s;
        A     = a;
        B     = b;
        if (s && !rst && (cyc + 1 >= model_free)) begin
            chk("idle_at_accept_busy", int'(busy), 0);
            r = model(a, b);
            r.done_cyc = cyc + 1 + r.k;
            exp_q.push_back(r);
            model_free = cyc + 1 + r.k + 2;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            drive(1'b0, '0, '0);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);
    endtask

    // Monitor
    int   hold_e = 0, hold_g = 0, hold_l = 0, hold_s = 0;
    logic prev_done = 1'b0;

    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                hold_e = 0; hold_g = 0; hold_l = 0; hold_s = 0;
                prev_done = 1'b0;
            end else begin
                if (prev_done) begin
                    chk("after_done_busy", int'(busy), 0);
                    chk("after_done_done", int'(done), 0);
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        r = exp_q.pop_front();
                        chk("done_cycle", cyc, r.done_cyc);
                        chk("E", int'(E), r.e);
                        chk("G", int'(G), r.g);
                        chk("L", int'(L), r.l);
                        chk("steps", int'(steps), r.k);
                        chk("busy_at_done", int'(busy), 1);
                        hold_e = r.e; hold_g = r.g; hold_l = r.l; hold_s = r.k;
                        $display("txn A=%02h B=%02h E=%0d G=%0d L=%0d steps=%0d cycle=%0d",
                                 r.a, r.b, E, G, L, steps, cyc);
                    end
                end else begin
                    chk("hold_EGL", {29'd0, E, G, L}, (hold_e << 2) | (hold_g << 1) | hold_l);
                    chk("hold_steps", int'(steps), hold_s);
                end
                prev_done = done;
            end
        end
    end

    // Stimulus
    initial begin
        logic [W-1:0] ra, rb;
        int mode;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);
        chk("rst_EGL",   {29'd0, E, G, L}, 0);
        chk("rst_steps", int'(steps), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        model_free = cyc + 1;

        // Equal operands: full walk.
        drive(1'b1, 8'hA5, 8'hA5);
        drain();
        // MSB pair decides.
        drive(1'b1, 8'hC0, 8'h40);
        drain();
        // Only the last pair differs.
        drive(1'b1, 8'h12, 8'h13);
        drain();

        // Requests during RUN/DONE are ignored.
        drive(1'b1, 8'h12, 8'h13);
        repeat (5) drive(1'b1, 8'hFF, 8'h00);
        drain();

        // Async reset in the middle of a compare.
        drive(1'b1, 8'h00, 8'h00);
        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_busy",  int'(busy),  0);
        chk("midrun_rst_done",  int'(done),  0);
        chk("midrun_rst_EGL",   {29'd0, E, G, L}, 0);
        chk("midrun_rst_steps", int'(steps), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        model_free = cyc + 1;
        repeat (6) drive(1'b0, '0, '0);
        drive(1'b1, 8'h3C, 8'h3D);
        drain();

        // Start held high: back-to-back compares.
        repeat (9) drive(1'b1, 8'hFF, 8'h00);
        drain();

        // Randomized traffic with held and gapped requests.
        for (int i = 0; i < 400; i++) begin
            ra   = W'($urandom);
            mode = $urandom_range(0, 3);
            if (mode == 0)      rb = ra;
            else if (mode == 1) rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            else                rb = W'($urandom);
            drive(($urandom_range(0, 3) != 0), ra, rb);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
